// File: rtl/sar_adc.sv
// Behavioural successive-approximation ADC: track-and-hold of a real input, MSB-first
// binary search over NBITS clocks, start/busy/done handshake.
module sar_adc #(
  parameter int  NBITS = 12,
  parameter real VREF  = 3.3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  real              A_in,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] D_out,
  output logic             ovr
);

  localparam int  IW  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam real LSB = VREF / (2.0 ** NBITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t           r_state;
  real              r_held;
  logic [NBITS-1:0] r_trial;
  logic [IW-1:0]    r_idx;
  logic [NBITS-1:0] w_test;

  assign w_test = r_trial | (NBITS'(1) << r_idx);

  // The edge leaving DONE lands in IDLE with done still high; that IDLE edge clears
  // done/busy or, with start held, re-enters SAMPLE so back-to-back runs take NBITS+3 clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_held  <= 0.0;
      r_trial <= '0;
      r_idx   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      D_out   <= '0;
      ovr     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy    <= 1'b1;
            r_state <= S_SAMPLE;
          end else begin
            busy <= 1'b0;
          end
        end
        S_SAMPLE: begin
          r_held  <= A_in;
          r_trial <= '0;
          r_idx   <= IW'(NBITS - 1);
          r_state <= S_CONVERT;
        end
        S_CONVERT: begin
          if (r_held >= real'(w_test) * LSB)
            r_trial <= w_test;
          if (r_idx == '0)
            r_state <= S_DONE;
          else
            r_idx <= r_idx - 1'b1;
        end
        S_DONE: begin
          D_out   <= r_trial;
          ovr     <= (r_held < 0.0) || (r_held >= VREF);
          done    <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_adc.sv
// Directed self-checking bench for sar_adc: table of single conversions plus
// hand-written sequences for reset, hold/lockout, mid-conversion reset and DAC loopback.
module tb_sar_adc;

  logic        clk;
  logic        rst_n;
  logic        start;
  real         A_in;
  logic        busy;
  logic        done;
  logic [11:0] D_out;
  logic        ovr;

  int total = 0;
  int bad   = 0;

  sar_adc #(.NBITS(12), .VREF(3.3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A_in  (A_in),
    .busy  (busy),
    .done  (done),
    .D_out (D_out),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    real         a;
    logic [11:0] code;
    logic        ov;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic real dac(input int code);
    return real'(code) * 3.3 / 4096.0;
  endfunction

  // Single conversion with a one-cycle start; checks latency, result, pulse width.
  task automatic run_conv(input string nm, input real a, input int exp_code, input int exp_ovr);
    int n;
    @(negedge clk);
    A_in  = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy_rise"}, int'(busy), 1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, n, 14);
    chk({nm, "_code"}, int'(D_out), exp_code);
    chk({nm, "_ovr"}, int'(ovr), exp_ovr);
    chk({nm, "_busy_at_done"}, int'(busy), 1);
    @(posedge clk); #1;
    chk({nm, "_done_width"}, int'(done), 0);
    chk({nm, "_busy_fall"}, int'(busy), 0);
  endtask

  vec_t vecs[8];
  int   codes[8];

  initial begin
    int n;
    int ndone;
    rst_n = 1'b0;
    start = 1'b1;
    A_in  = 1.0;

    vecs[0] = '{"nominal_1v0", 1.0,  12'd1241, 1'b0};
    vecs[1] = '{"zero",        0.0,  12'd0,    1'b0};
    vecs[2] = '{"fullscale",   3.3,  12'd4095, 1'b1};
    vecs[3] = '{"negative",   -0.1,  12'd0,    1'b1};
    vecs[4] = '{"two_volt",    2.0,  12'd2482, 1'b0};
    vecs[5] = '{"half_volt",   0.5,  12'd620,  1'b0};
    vecs[6] = '{"three_volt",  3.0,  12'd3723, 1'b0};
    vecs[7] = '{"over_5v",     5.0,  12'd4095, 1'b1};

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_dout", int'(D_out), 0);
      chk("rst_ovr",  int'(ovr), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 8; i++)
      run_conv(vecs[i].name, vecs[i].a, int'(vecs[i].code), int'(vecs[i].ov));

    // Hold: input moves after the sample edge, start pulses during CONVERT are ignored.
    @(negedge clk);
    A_in  = 0.5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    A_in  = 3.0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      start = (k < 6) ? logic'(k % 2) : 1'b0;
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("hold_done_count", ndone, 1);
    chk("hold_code", int'(D_out), 620);
    chk("hold_busy_end", int'(busy), 0);

    // Reset five cycles into CONVERT: aborts with no done, clears D_out.
    @(negedge clk);
    A_in  = 1.0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_dout", int'(D_out), 0);
    ndone = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("midrst_no_done", ndone, 0);
    run_conv("after_rst", 1.0, 1241, 0);

    // DAC loopback with start held high: one result every 15 clocks.
    codes[0] = 0;
    codes[1] = 1;
    codes[2] = 2048;
    codes[3] = 4095;
    for (int i = 4; i < 8; i++) codes[i] = int'($urandom_range(4095));
    @(negedge clk);
    A_in  = dac(codes[0]);
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 40);
      if (i > 0) chk($sformatf("loop%0d_period", i), n, 15);
      total++;
      if (!(int'(D_out) == codes[i] || (codes[i] > 0 && int'(D_out) == codes[i] - 1))) begin
        bad++;
        $display("FAIL loop%0d_code: got %0d expected %0d (or one less)", i, D_out, codes[i]);
      end
      if (i < 7) A_in = dac(codes[i + 1]);
      else       start = 1'b0;
    end
    @(posedge clk); #1;
    chk("loop_busy_end", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
